mem_ctrl: RTL and testbench

//  Bus-master front end for the single-port, 16-bit word-addressed main memory (sync read, 1-cycle latency).

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_ctrl_if.sv | 24 ++
 rtl/mem_ctrl.sv | 80 ++++++++
 tb/tb_mem_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, memory depth and FSM state encoding for the memory controller.
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int MEM_DEPTH = 16384;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response handshakes plus memory strobes; slave is the controller, master its surroundings.
interface mem_ctrl_if;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [mem_pkg::ADDR_W-1:0] req_addr;
    logic [mem_pkg::DATA_W-1:0] req_wdata;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [mem_pkg::DATA_W-1:0] resp_rdata;
    logic                       resp_err;
    logic [mem_pkg::ADDR_W-1:0] mem_addr;
    logic [mem_pkg::DATA_W-1:0] mem_data_in;
    logic                       mem_write_enable;
    logic [mem_pkg::DATA_W-1:0] mem_data_out;
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_data_in, mem_write_enable
    );
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_data_in, mem_write_enable
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-request bus master for a sync-read word memory (MAR/MBR, valid/ready on both sides).
// Define MEM_CTRL_RANGE_CHECK_EN to answer out-of-range addresses with resp_err instead of touching memory.
import mem_pkg::*;
module mem_ctrl (
    input logic       clk,
    input logic       reset,
    mem_ctrl_if.slave bus
);
    state_t              state;
    logic [ADDR_W-1:0]   mar;
    logic [DATA_W-1:0]   mbr;
    logic [DATA_W-1:0]   data_in;
    logic                op_write;
    logic                ready;
    logic                valid;
    logic                err;
    logic                wen;
    logic                oor;
`ifdef MEM_CTRL_RANGE_CHECK_EN
    assign oor = bus.req_addr >= ADDR_LIMIT;
`else
    assign oor = 1'b0;
`endif
    assign bus.req_ready        = ready;
    assign bus.resp_valid       = valid;
    assign bus.resp_err         = err;
    assign bus.resp_rdata       = (valid && !op_write && !err) ? mbr : '0;
    assign bus.mem_addr         = mar;
    assign bus.mem_data_in      = data_in;
    assign bus.mem_write_enable = wen;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mar      <= '0;
            mbr      <= '0;
            data_in  <= '0;
            op_write <= 1'b0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            err      <= 1'b0;
            wen      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_write <= bus.req_write;
                    mbr      <= bus.req_wdata;
                    ready    <= 1'b0;
                    // Rejected addresses leave MAR and the memory pins untouched.
                    if (oor) begin
                        state <= RESP;
                        valid <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state <= ISSUE;
                        mar   <= bus.req_addr;
                        wen   <= bus.req_write;
                        if (bus.req_write) data_in <= bus.req_wdata;
                    end
                end
                ISSUE: begin
                    wen   <= 1'b0;
                    state <= op_write ? RESP : CAPTURE;
                    valid <= op_write;
                end
                CAPTURE: begin
                    mbr   <= bus.mem_data_out;
                    state <= RESP;
                    valid <= 1'b1;
                end
                RESP: if (bus.resp_ready) begin
                    state <= IDLE;
                    valid <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors against mem_ctrl with a behavioural sync-read memory.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n = 0;
    int errs = 0;
    int lat;
    int wcnt = 0;
    int w0;
    logic [15:0] mem [0:65535];
    mem_ctrl_if bus();
    mem_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            mem[bus.mem_addr] <= bus.mem_data_in;
            wcnt <= wcnt + 1;
        end
        bus.mem_data_out <= mem[bus.mem_addr];
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        chk("req_ready_before_send", 32'(bus.req_ready), 1);
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask
    task automatic wait_resp();
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        bus.mem_data_out = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_wen", 32'(bus.mem_write_enable), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_rdata", 32'(bus.resp_rdata), 0);
        chk("rst_err", 32'(bus.resp_err), 0);
        tick();
        // write 0xBEEF @0x0010
        w0 = wcnt;
        send(1'b1, 16'h0010, 16'hBEEF);
        chk("wr_issue_wen", 32'(bus.mem_write_enable), 1);
        chk("wr_issue_addr", 32'(bus.mem_addr), 32'h0010);
        chk("wr_issue_data", 32'(bus.mem_data_in), 32'hBEEF);
        chk("wr_issue_ready", 32'(bus.req_ready), 0);
        wait_resp();
        chk("wr_latency", 32'(lat), 2);
        chk("wr_rdata", 32'(bus.resp_rdata), 0);
        chk("wr_err", 32'(bus.resp_err), 0);
        chk("wr_wen_after", 32'(bus.mem_write_enable), 0);
        chk("wr_strobes", 32'(wcnt - w0), 1);
        tick();
        chk("wr_resp_drop", 32'(bus.resp_valid), 0);
        chk("wr_ready_back", 32'(bus.req_ready), 1);
        chk("wr_addr_hold", 32'(bus.mem_addr), 32'h0010);
        // read @0x0010
        w0 = wcnt;
        send(1'b0, 16'h0010, 16'h5555);
        chk("rd_issue_wen", 32'(bus.mem_write_enable), 0);
        chk("rd_issue_addr", 32'(bus.mem_addr), 32'h0010);
        chk("rd_data_in_hold", 32'(bus.mem_data_in), 32'hBEEF);
        wait_resp();
        chk("rd_latency", 32'(lat), 3);
        chk("rd_rdata", 32'(bus.resp_rdata), 32'hBEEF);
        chk("rd_err", 32'(bus.resp_err), 0);
        tick();
        chk("rd_resp_drop", 32'(bus.resp_valid), 0);
        chk("rd_strobes", 32'(wcnt - w0), 0);
        // read held by resp_ready low, with ignored requests
        w0 = wcnt;
        bus.resp_ready = 1'b0;
        send(1'b0, 16'h0010, 16'h0000);
        wait_resp();
        chk("hold_latency", 32'(lat), 3);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = i[0];
            bus.req_write = 1'b1;
            bus.req_addr = 16'h0030;
            bus.req_wdata = 16'h1111;
            tick();
            chk("hold_valid", 32'(bus.resp_valid), 1);
            chk("hold_rdata", 32'(bus.resp_rdata), 32'hBEEF);
            chk("hold_req_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("hold_release", 32'(bus.resp_valid), 0);
        chk("hold_ready_back", 32'(bus.req_ready), 1);
        chk("hold_no_strobe", 32'(wcnt - w0), 0);
        // reset during ISSUE of a read
        send(1'b0, 16'h0010, 16'h0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", 32'(bus.req_ready), 1);
        chk("mid_rst_valid", 32'(bus.resp_valid), 0);
        chk("mid_rst_wen", 32'(bus.mem_write_enable), 0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 0);
        tick();
        tick();
        chk("mid_rst_no_resp", 32'(bus.resp_valid), 0);
        send(1'b0, 16'h0010, 16'h0000);
        wait_resp();
        chk("post_rst_latency", 32'(lat), 3);
        chk("post_rst_rdata", 32'(bus.resp_rdata), 32'hBEEF);
        tick();
        // out-of-range write @0x4000, then last in-range read @0x3FFF
        w0 = wcnt;
        send(1'b1, 16'h4000, 16'hCAFE);
        wait_resp();
`ifdef MEM_CTRL_RANGE_CHECK_EN
        chk("oor_latency", 32'(lat), 1);
        chk("oor_err", 32'(bus.resp_err), 1);
        chk("oor_rdata", 32'(bus.resp_rdata), 0);
        chk("oor_no_strobe", 32'(wcnt - w0), 0);
`else
        chk("oor_latency", 32'(lat), 2);
        chk("oor_err", 32'(bus.resp_err), 0);
        chk("oor_strobe", 32'(wcnt - w0), 1);
`endif
        tick();
        chk("oor_resp_drop", 32'(bus.resp_valid), 0);
        chk("oor_err_clear", 32'(bus.resp_err), 0);
        send(1'b1, 16'h3FFF, 16'h7A5C);
        wait_resp();
        chk("edge_wr_latency", 32'(lat), 2);
        chk("edge_wr_err", 32'(bus.resp_err), 0);
        tick();
        send(1'b0, 16'h3FFF, 16'h0000);
        wait_resp();
        chk("edge_rd_latency", 32'(lat), 3);
        chk("edge_rd_err", 32'(bus.resp_err), 0);
        chk("edge_rd_rdata", 32'(bus.resp_rdata), 32'h7A5C);
        tick();
`ifndef MEM_CTRL_RANGE_CHECK_EN
        send(1'b0, 16'h4000, 16'h0000);
        wait_resp();
        chk("oor_rd_rdata", 32'(bus.resp_rdata), 32'hCAFE);
        tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
